// File: rtl/vx_commit_arbiter.sv
// vx_commit_arbiter: fixed-priority commit-lane arbiter with starvation override,
// multi-beat grant lock and a 2-entry output buffer that decouples ready_in from ready_out.

// Per-input wait counter: counts consecutive cycles an input is valid but unserved.
module vx_commit_arbiter_wait #(
  parameter int MAX_WAIT = 15,
  parameter int WAIT_W   = $clog2(MAX_WAIT + 1)
) (
  input  logic clk,
  input  logic reset,
  input  logic i_valid,
  input  logic i_fire,
  output logic o_sat
);
  logic [WAIT_W-1:0] r_cnt;

  // Clear on service or idle; otherwise count up, saturating at the bound
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                        r_cnt <= '0;
    else if (i_fire || !i_valid)       r_cnt <= '0;
    else if (r_cnt != WAIT_W'(MAX_WAIT)) r_cnt <= r_cnt + 1'b1;
  end

  assign o_sat = (r_cnt == WAIT_W'(MAX_WAIT));
endmodule

module vx_commit_arbiter #(
  parameter int NUM_INPUTS = 4,
  parameter int DATAW      = 64,
  parameter int MAX_WAIT   = 15,
  parameter int SEL_W      = $clog2(NUM_INPUTS),
  parameter int WAIT_W     = $clog2(MAX_WAIT + 1)
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic [NUM_INPUTS-1:0]                i_valid_in,
  input  logic [NUM_INPUTS-1:0][DATAW-1:0]     i_data_in,
  input  logic [NUM_INPUTS-1:0]                i_eop_in,
  output logic [NUM_INPUTS-1:0]                o_ready_in,
  output logic                                 o_valid_out,
  output logic [DATAW-1:0]                     o_data_out,
  output logic                                 o_eop_out,
  output logic [SEL_W-1:0]                     o_sel_out,
  input  logic                                 i_ready_out,
  output logic [31:0]                          o_starved_grants
);
  if (MAX_WAIT < 1)   begin : g_bad_wait $error("MAX_WAIT must be >= 1");   end
  if (NUM_INPUTS < 2) begin : g_bad_num  $error("NUM_INPUTS must be >= 2"); end

  typedef struct packed {
    logic [DATAW-1:0] data;
    logic             eop;
    logic [SEL_W-1:0] sel;
  } ent_t;

  ent_t                  r_mem [0:1];
  logic                  r_wp, r_rp;
  logic [1:0]            r_cnt;
  logic                  r_locked;
  logic [SEL_W-1:0]      r_lock_idx;
  logic [31:0]           r_starved;

  logic [NUM_INPUTS-1:0] w_sat;
  logic [SEL_W-1:0]      w_sel;
  logic                  w_starve;
  logic                  w_full, w_fire, w_pop;
  ent_t                  w_ent;

  // One wait counter per input
  for (genvar g = 0; g < NUM_INPUTS; g++) begin : g_wait
    vx_commit_arbiter_wait #(.MAX_WAIT(MAX_WAIT), .WAIT_W(WAIT_W)) u_wait (
      .clk    (clk),
      .reset  (reset),
      .i_valid(i_valid_in[g]),
      .i_fire (w_fire && (w_sel == SEL_W'(g))),
      .o_sat  (w_sat[g])
    );
  end

  // Selection: lock holds the lane; else starved inputs first; else fixed priority
  always_comb begin
    w_sel    = '0;
    w_starve = 1'b0;
    if (r_locked) begin
      w_sel = r_lock_idx;
    end else begin
      for (int i = NUM_INPUTS-1; i >= 0; i--)
        if (i_valid_in[i] && w_sat[i]) begin
          w_sel    = SEL_W'(i);
          w_starve = 1'b1;
        end
      if (!w_starve)
        for (int i = NUM_INPUTS-1; i >= 0; i--)
          if (i_valid_in[i]) w_sel = SEL_W'(i);
    end
  end

  assign w_full = (r_cnt == 2'd2);
  assign w_pop  = o_valid_out && i_ready_out;

  // Grant: one-hot on the selected input when the buffer has room
  always_comb begin
    o_ready_in = '0;
    if (!w_full && reset) o_ready_in[w_sel] = 1'b1;
  end

  assign w_fire = i_valid_in[w_sel] && o_ready_in[w_sel];
  assign w_ent  = '{data: i_data_in[w_sel], eop: i_eop_in[w_sel], sel: w_sel};

  // Output buffer: 2-entry ring, full derived from registered count only
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_mem[0] <= '0;
      r_mem[1] <= '0;
      r_wp     <= 1'b0;
      r_rp     <= 1'b0;
      r_cnt    <= '0;
    end else begin
      if (w_fire) begin
        r_mem[r_wp] <= w_ent;
        r_wp        <= ~r_wp;
      end
      if (w_pop) r_rp <= ~r_rp;
      case ({w_fire, w_pop})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  // Packet lock and starvation-grant counter, both advanced on fire
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_locked   <= 1'b0;
      r_lock_idx <= '0;
      r_starved  <= '0;
    end else if (w_fire) begin
      r_locked   <= !i_eop_in[w_sel];
      r_lock_idx <= w_sel;
      if (w_starve) r_starved <= r_starved + 32'd1;
    end
  end

  assign o_valid_out      = (r_cnt != 2'd0);
  assign o_data_out       = r_mem[r_rp].data;
  assign o_eop_out        = r_mem[r_rp].eop;
  assign o_sel_out        = r_mem[r_rp].sel;
  assign o_starved_grants = r_starved;
endmodule

// File: tb/tb_vx_commit_arbiter.sv
// Randomized + directed bench for vx_commit_arbiter against a queue-based reference model.
module tb_vx_commit_arbiter;
  localparam int N  = 4;
  localparam int DW = 64;
  localparam int MW = 15;
  localparam int SW = 2;

  logic                  clk = 1'b0;
  logic                  reset = 1'b1;
  logic [N-1:0]          vin, ein, rin;
  logic [N-1:0][DW-1:0]  din;
  logic                  vout, eout, rout;
  logic [DW-1:0]         dout;
  logic [SW-1:0]         sout;
  logic [31:0]           sg;

  vx_commit_arbiter #(.NUM_INPUTS(N), .DATAW(DW), .MAX_WAIT(MW)) dut (
    .clk(clk), .reset(reset),
    .i_valid_in(vin), .i_data_in(din), .i_eop_in(ein), .o_ready_in(rin),
    .o_valid_out(vout), .o_data_out(dout), .o_eop_out(eout), .o_sel_out(sout),
    .i_ready_out(rout), .o_starved_grants(sg)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model state
  typedef struct { logic [DW-1:0] data; bit eop; int sel; } ent_t;
  int   m_wait [N];
  bit   m_lock;
  int   m_lidx;
  ent_t m_q [$];
  int   m_starv;

  task automatic m_clear();
    foreach (m_wait[i]) m_wait[i] = 0;
    m_lock = 0; m_lidx = 0; m_starv = 0;
    m_q.delete();
  endtask

  // Called just after a negedge with inputs applied; checks outputs, then advances one cycle
  task automatic step();
    int sel; bit starve; bit found; bit full; bit fire; bit pop;
    logic [N-1:0] exp_rdy;
    ent_t e;
    #1;
    sel = 0; starve = 0; found = 0;
    if (m_lock) sel = m_lidx;
    else begin
      for (int i = 0; i < N; i++)
        if (!found && vin[i] && m_wait[i] == MW) begin sel = i; starve = 1; found = 1; end
      for (int i = 0; i < N; i++)
        if (!found && vin[i]) begin sel = i; found = 1; end
    end
    full    = (m_q.size() == 2);
    exp_rdy = full ? '0 : (N'(1) << sel);
    chk("ready_in", rin, exp_rdy);
    chk("valid_out", vout, m_q.size() != 0);
    if (m_q.size() != 0) begin
      chk("data_out", dout, m_q[0].data);
      chk("eop_out", eout, m_q[0].eop);
      chk("sel_out", sout, m_q[0].sel);
    end
    chk("starved_grants", sg, m_starv);
    fire = vin[sel] && !full;
    pop  = (m_q.size() != 0) && rout;
    e    = '{din[sel], ein[sel], sel};
    @(posedge clk);
    if (pop)  void'(m_q.pop_front());
    if (fire) m_q.push_back(e);
    for (int i = 0; i < N; i++) begin
      if (fire && i == sel) m_wait[i] = 0;
      else if (vin[i])      m_wait[i] = (m_wait[i] < MW) ? m_wait[i] + 1 : MW;
      else                  m_wait[i] = 0;
    end
    if (fire) begin
      if (starve) m_starv++;
      m_lock = !e.eop;
      m_lidx = sel;
    end
    @(negedge clk);
  endtask

  // Asserts reset mid-cycle, checks the asynchronous reset state, releases at the next negedge
  task automatic do_reset();
    vin = '0; ein = '0; din = '0; rout = 1'b0;
    reset = 1'b0;
    #1;
    chk("rst_ready_in", rin, 0);
    chk("rst_valid_out", vout, 0);
    chk("rst_data_out", dout, 0);
    chk("rst_eop_out", eout, 0);
    chk("rst_sel_out", sout, 0);
    chk("rst_starved", sg, 0);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    m_clear();
  endtask

  initial begin
    m_clear();
    vin = '0; ein = '0; din = '0; rout = 1'b0;
    #2;
    do_reset();

    // Fixed priority + starvation: inputs 0 and 2 always valid
    rout = 1'b1; vin = 4'b0101; ein = 4'b1111;
    for (int c = 0; c < 17; c++) begin
      din[0] = DW'(c); din[2] = DW'(100 + c);
      #1;
      if (c < 15)       chk("starve_prio0", rin, 4'b0001);
      else if (c == 15) chk("starve_grant2", rin, 4'b0100);
      else              chk("starve_back0", rin, 4'b0001);
      step();
    end
    chk("starve_count", sg, 1);
    vin = '0;
    step(); step();
    do_reset();

    // Packet lock: input 1 sends 3 beats, input 0 joins on beat 2
    rout = 1'b1;
    for (int c = 0; c < 6; c++) begin
      vin = (c == 0) ? 4'b0010 : (c < 3) ? 4'b0011 : 4'b0001;
      ein = (c == 2) ? 4'b0011 : 4'b0001;
      din[1] = DW'(32'h1000 + c); din[0] = DW'(32'h2000 + c);
      #1;
      if (c == 1 || c == 2) chk("lock_hold1", rin, 4'b0010);
      if (c == 3)           chk("lock_release0", rin, 4'b0001);
      if (c >= 1 && c <= 3) chk("lock_seq_sel1", sout, 1);
      if (c == 4)           chk("lock_seq_sel0", sout, 0);
      step();
    end
    vin = '0; step(); step();
    do_reset();

    // Backpressure: only two beats accepted while ready_out is low
    vin = 4'b1000; ein = 4'b1111; rout = 1'b0;
    din[3] = 64'hA; step();
    din[3] = 64'hB; step();
    din[3] = 64'hC; #1; chk("bp_full_ready", rin, 0); step();
    rout = 1'b1; #1; chk("bp_still_full", rin, 0); chk("bp_head_A", dout, 64'hA); step();
    #1; chk("bp_reassert", rin, 4'b1000); chk("bp_head_B", dout, 64'hB); step();
    vin = '0; #1; chk("bp_head_C", dout, 64'hC); chk("bp_sel3", sout, 3); step();
    step();
    do_reset();

    // Simultaneous push/pop with ready_out toggling
    vin = 4'b0001; ein = 4'b1111;
    for (int c = 0; c < 20; c++) begin
      rout = (c % 2 == 0);
      din[0] = {$urandom, $urandom};
      step();
    end
    vin = '0; rout = 1'b1; step(); step(); step();
    do_reset();

    // Locked input stalls: input 1 drops valid mid-packet
    rout = 1'b1;
    for (int c = 0; c < 9; c++) begin
      vin = (c == 0) ? 4'b0010 : (c < 6) ? 4'b0001 : (c == 6) ? 4'b0011 : 4'b0001;
      ein = (c == 6) ? 4'b0011 : 4'b0001;
      din[1] = DW'(32'h3000 + c); din[0] = DW'(32'h4000 + c);
      #1;
      if (c >= 1 && c <= 6) chk("stall_hold1", rin, 4'b0010);
      if (c == 7)           chk("stall_release0", rin, 4'b0001);
      step();
    end
    vin = '0; step(); step();
    do_reset();

    // Randomized traffic
    for (int c = 0; c < 3000; c++) begin
      vin  = N'($urandom);
      ein  = N'($urandom) | N'($urandom);
      rout = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < N; i++) din[i] = {$urandom, $urandom};
      step();
    end

    // Reset mid-traffic with two beats buffered
    vin = 4'b0001; ein = 4'b0001; rout = 1'b0;
    do_reset();
    vin = 4'b0001; ein = 4'b1111; rout = 1'b0;
    for (int c = 0; c < 3; c++) begin din[0] = DW'(c + 7); step(); end
    do_reset();
    chk("post_rst_empty", vout, 0);
    step(); step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
